// File: rtl/rand_chk_pkg.sv
// Shared types, sizes and the xorshift32 step for the burst checker and its models.
package rand_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } chk_state_e;

  localparam int CNT_W         = 9;
  localparam int BURST_LEN_DEF = 256;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/xorshift32_step.sv
// Combinational single xorshift32 step, used to predict the next word of a burst.
module xorshift32_step
  import rand_chk_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = xorshift32(x);

endmodule

// File: rtl/rand_burst_checker.sv
// Checks bursts of xorshift32 words against a resyncing prediction and reports one record per burst.
// Optional RAND_CHK_SIG_EN adds a rotate-xor signature of the burst on out_sig.
//
// state  | meaning
// IDLE   | waiting for the first word of a burst
// RUN    | checking words, counting idle gap
// REPORT | record held on out_* until out_valid && out_ready
module rand_burst_checker
  import rand_chk_pkg::*;
#(
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pass,
  output logic             out_abort,
  output logic             out_drop,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic [31:0]      out_first
`ifdef RAND_CHK_SIG_EN
  ,
  output logic [31:0]      out_sig
`endif
);

  localparam int GAP_W = (GAP_TIMEOUT < 2) ? 1 : $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  chk_state_e       state_q, state_d;
  logic [31:0]      expected_q, first_q, step_out;
  logic [CNT_W-1:0] count_q, err_q, cnt_inc, err_inc;
  logic [GAP_W-1:0] gap_q, gap_inc;
  logic             start, run_word, done, timeout, drop_evt;

  xorshift32_step u_step (
    .x (in_data),
    .y (step_out)
  );

  assign cnt_inc  = count_q + CNT_W'(1);
  assign err_inc  = ((in_data != expected_q) && (err_q != ERR_MAX)) ? err_q + CNT_W'(1) : err_q;
  assign gap_inc  = gap_q + GAP_W'(1);
  assign start    = in_valid && ((state_q == IDLE) || ((state_q == REPORT) && out_ready));
  assign run_word = (state_q == RUN) && in_valid;
  assign done     = run_word && (cnt_inc == LAST_CNT);
  assign timeout  = (state_q == RUN) && !in_valid && (GAP_TIMEOUT != 0) && (gap_inc == GAP_LIM);
  assign drop_evt = (state_q == REPORT) && in_valid && !out_ready;
  assign out_valid = (state_q == REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (done || timeout) state_d = REPORT;
      REPORT:  if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Prediction always follows the received word so one bad word costs exactly two errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q <= '0;
      first_q    <= '0;
      count_q    <= '0;
      err_q      <= '0;
      gap_q      <= '0;
    end else if (start) begin
      expected_q <= step_out;
      first_q    <= in_data;
      count_q    <= CNT_W'(1);
      err_q      <= '0;
      gap_q      <= '0;
    end else if (run_word) begin
      expected_q <= step_out;
      count_q    <= cnt_inc;
      err_q      <= err_inc;
      gap_q      <= '0;
    end else if (state_q == RUN) begin
      gap_q      <= gap_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pass    <= 1'b0;
      out_abort   <= 1'b0;
      out_drop    <= 1'b0;
      out_count   <= '0;
      out_err_cnt <= '0;
      out_first   <= '0;
    end else if (done) begin
      out_pass    <= (err_inc == '0);
      out_abort   <= 1'b0;
      out_drop    <= 1'b0;
      out_count   <= cnt_inc;
      out_err_cnt <= err_inc;
      out_first   <= first_q;
    end else if (timeout) begin
      out_pass    <= 1'b0;
      out_abort   <= 1'b1;
      out_drop    <= 1'b0;
      out_count   <= count_q;
      out_err_cnt <= err_q;
      out_first   <= first_q;
    end else if (drop_evt) begin
      out_pass    <= 1'b0;
      out_drop    <= 1'b1;
    end
  end

`ifdef RAND_CHK_SIG_EN
  logic [31:0] sig_q, sig_next;

  assign sig_next = {sig_q[30:0], sig_q[31]} ^ in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= '0;
      out_sig <= '0;
    end else begin
      if (start)         sig_q <= in_data;
      else if (run_word) sig_q <= sig_next;
      if (done)          out_sig <= sig_next;
      else if (timeout)  out_sig <= sig_q;
    end
  end
`endif

endmodule

// File: tb/tb_rand_burst_checker.sv
// Directed bench for rand_burst_checker: clean, corrupted, gapped, aborted, dropped and reset bursts.
module tb_rand_burst_checker;
  import rand_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_pass, out_abort, out_drop;
  logic [8:0]  out_count, out_err_cnt;
  logic [31:0] out_first;
`ifdef RAND_CHK_SIG_EN
  logic [31:0] out_sig;
  logic [31:0] exp_sig = '0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  rand_burst_checker #(.BURST_LEN(256), .GAP_TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pass    (out_pass),
    .out_abort   (out_abort),
    .out_drop    (out_drop),
    .out_count   (out_count),
    .out_err_cnt (out_err_cnt),
    .out_first   (out_first)
`ifdef RAND_CHK_SIG_EN
    ,
    .out_sig     (out_sig)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nwords of the xorshift32 sequence from seed; word bad_idx gets bit 0 flipped,
  // and every gap_every words a 3-cycle hole is inserted.
  task automatic run_burst(input logic [31:0] seed, input int nwords, input int bad_idx,
                           input int gap_every);
    logic [31:0] w;
    logic [31:0] d;
    w = seed;
    for (int i = 1; i <= nwords; i++) begin
      if (gap_every != 0 && i > 1 && ((i - 1) % gap_every) == 0) begin
        in_valid = 1'b0;
        repeat (3) tick();
      end
      d = (i == bad_idx) ? (w ^ 32'h1) : w;
      in_valid = 1'b1;
      in_data  = d;
`ifdef RAND_CHK_SIG_EN
      exp_sig = (i == 1) ? d : ({exp_sig[30:0], exp_sig[31]} ^ d);
`endif
      tick();
      w = xorshift32(w);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_rec(input string tag, input logic [8:0] cnt, input logic [8:0] err,
                           input logic pass, input logic abort, input logic drop,
                           input logic [31:0] first);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".count"}, 32'(out_count), 32'(cnt));
    check({tag, ".err"},   32'(out_err_cnt), 32'(err));
    check({tag, ".pass"},  32'(out_pass), 32'(pass));
    check({tag, ".abort"}, 32'(out_abort), 32'(abort));
    check({tag, ".drop"},  32'(out_drop), 32'(drop));
    check({tag, ".first"}, out_first, first);
`ifdef RAND_CHK_SIG_EN
    check({tag, ".sig"}, out_sig, exp_sig);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".pass"},  32'(out_pass), 32'd0);
    check({tag, ".abort"}, 32'(out_abort), 32'd0);
    check({tag, ".drop"},  32'(out_drop), 32'd0);
    check({tag, ".count"}, 32'(out_count), 32'd0);
    check({tag, ".err"},   32'(out_err_cnt), 32'd0);
    check({tag, ".first"}, out_first, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_zero("reset");
    check("step_1", xorshift32(32'd1), 32'h0004_2021);
    check("step_7", xorshift32(32'd7), 32'h001C_E0E7);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    run_burst(32'd1, 256, 0, 0);
    check_rec("clean", 9'd256, 9'd0, 1'b1, 1'b0, 1'b0, 32'd1);
    tick();
    check("clean.ack", 32'(out_valid), 32'd0);

    run_burst(32'd1, 256, 10, 0);
    check_rec("bad10", 9'd256, 9'd2, 1'b0, 1'b0, 1'b0, 32'd1);
    tick();

    run_burst(32'd1, 256, 0, 16);
    check_rec("gaps", 9'd256, 9'd0, 1'b1, 1'b0, 1'b0, 32'd1);
    tick();

    run_burst(32'd1, 100, 0, 0);
    repeat (63) tick();
    check("abort.early", 32'(out_valid), 32'd0);
    tick();
    check_rec("abort", 9'd100, 9'd0, 1'b0, 1'b1, 1'b0, 32'd1);
    tick();
    check("abort.ack", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    run_burst(32'd1, 256, 0, 0);
    check_rec("hold", 9'd256, 9'd0, 1'b1, 1'b0, 1'b0, 32'd1);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 2);
      in_data  = 32'hDEAD_0000 + 32'(c);
      tick();
      check("hold.valid", 32'(out_valid), 32'd1);
      check("hold.count", 32'(out_count), 32'd256);
      check("hold.first", out_first, 32'd1);
    end
    in_valid = 1'b0;
    check("hold.drop", 32'(out_drop), 32'd1);
    check("hold.pass", 32'(out_pass), 32'd0);
    check("hold.err",  32'(out_err_cnt), 32'd0);

    out_ready = 1'b1;
    run_burst(32'd7, 256, 0, 0);
    check_rec("seed7", 9'd256, 9'd0, 1'b1, 1'b0, 1'b0, 32'd7);
    tick();

    run_burst(32'd3, 128, 0, 0);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst.idle", 32'(out_valid), 32'd0);

    run_burst(32'h1234_5678, 256, 0, 0);
    check_rec("fresh", 9'd256, 9'd0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    tick();
    check("fresh.ack", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
